fir_mac_engine: RTL and testbench
=================================

// Module: fir_mac_engine
// PURPOSE
//   Time-multiplexed N-tap FIR engine built around one fixed-point multiply-accumulate (MAC) unit.
//   - Accepts one input sample per valid/ready handshake and stores it in a circular delay line.
//   - Computes sum(h[k]*x[n-k]) over NUM_TAPS cycles.
//   - Rounds, shifts and saturates the result, then presents it on a valid/ready output port.
//   - Sits between the sample source and the decimation/output stage of the FIR datapath.
// PARAMETERS
//   INPUT_WIDTH   16  signed sample width
//   COEFF_WIDTH   16  signed coefficient width
//   NUM_TAPS      8   number of taps; must be >= 2; need not be a power of 2
//   ACCUM_WIDTH   35  accumulator width; default = INPUT_WIDTH+COEFF_WIDTH+clog2(NUM_TAPS)
//   OUTPUT_WIDTH  16  signed output width
//   OUT_SHIFT     15  arithmetic right shift applied to the accumulator before saturation
// PORTS
//   clk        in   1             clock; all logic on the rising edge
//   reset      in   1             asynchronous, active-high reset
//   in_valid   in   1             in_sample is valid
//   in_ready   out  1             engine can accept a sample
//   in_sample  in   INPUT_WIDTH   signed input sample
//   coef_we    in   1             coefficient write strobe
//   coef_addr  in   clog2(NUM_TAPS)  tap index k
//   coef_data  in   COEFF_WIDTH   signed coefficient h[k]
//   out_valid  out  1             out_data is valid
//   out_ready  in   1             downstream accepts out_data
//   out_data   out  OUTPUT_WIDTH  rounded, saturated filter output
//   out_sat    out  1             out_data was clipped; qualified by out_valid
//   busy       out  1             state != IDLE
// BEHAVIOUR
//   Reset
//   - Async clear of the FSM to IDLE, delay line, coefficients, accumulator, product register and pointers.
//   - Outputs: in_ready=1, out_valid=0, out_data=0, out_sat=0, busy=0.
//   - A reset mid-operation discards the sample in flight.
//   FSM states: IDLE -> MAC -> DRAIN -> ROUND -> HOLD -> IDLE
//   - IDLE: in_ready=1. On in_valid&&in_ready:
//     - write the sample to dline[wr_ptr];
//     - clear acc and k;
//     - go to MAC.
//   - MAC, NUM_TAPS cycles:
//     - prod_r <= dline[(wr_ptr-k) mod NUM_TAPS] * coef[k];
//     - acc <= acc + prod_r, except on the first MAC cycle;
//     - k increments; at k==NUM_TAPS-1, go to DRAIN.
//   - DRAIN: acc <= acc + prod_r (last product); advance wr_ptr with explicit wrap at NUM_TAPS-1.
//   - ROUND: register out_data and out_sat from acc; go to HOLD.
//   - HOLD: out_valid=1; out_data and out_sat are held stable. On out_valid&&out_ready, go to IDLE.
//   Timing
//   - Latency: out_valid rises on the NUM_TAPS+2 edge after the accepting edge.
//   - Minimum period: NUM_TAPS+4 cycles per sample with out_ready tied high.
//   - in_ready is high only in IDLE. No skid buffer: in_valid may be held indefinitely.
//   Arithmetic
//   - Product is full-precision signed (INPUT_WIDTH+COEFF_WIDTH), sign-extended into acc.
//   - acc wraps two's-complement; the default width cannot overflow.
//   - Rounding is round-half-up: r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT. When OUT_SHIFT=0, r = acc.
//   - If r lies outside the signed OUTPUT_WIDTH range, clamp to max/min and set out_sat=1.
//   Coefficients
//   - coef_we is honoured only in IDLE; it is ignored in every other state.
//   - coef_addr >= NUM_TAPS is ignored.
//   - A write coinciding with a sample accept takes effect from the next computation.
//   - Delay line is zero at reset, so outputs start as if preceded by zeros.
// STRUCTURE
//   - Shared package fir_pkg:
//     - FSM state encoding;
//     - clog2 helper;
//     - saturate/round function shared with other FIR stages.
//   - Sub-module fir_delay_line:
//     - circular sample buffer of NUM_TAPS words;
//     - wr_ptr, write port and tap-offset read port.
//   - This module holds the FSM, coefficient register file, MAC pipeline and round/saturate stage.
// TESTING (defaults unless stated)
//   1 Impulse: h[k]=k*1024, feed x=16384 then 8 zeros
//     -> outputs 0,512,1024,...,3584 then 0; out_sat=0.
//   2 Saturation: all h=32767
//     -> 8x x=32767 gives 8th out=32767, sat=1;
//     -> then 8x x=-32768 gives 8th out=-32768, sat=1.
//   3 Rounding: h[0]=1, others 0
//     -> x=16384 gives out=1; x=16383 gives out=0; x=-16384 gives out=0; x=-16385 gives out=-1.
//   4 Backpressure: out_ready=0 for 20 cycles, in_valid held high with the next sample
//     -> out_data/out_sat stable, out_valid=1, in_ready=0;
//     -> next sample accepted the cycle after the handshake.
//   5 Latency/ordering: out_valid rises exactly 10 edges after the accept edge;
//     -> 300 random samples match a golden model across many wr_ptr wraps.
//   6 Busy/reset: coef_we during MAC has no effect on the result;
//     -> reset asserted mid-MAC gives out_valid=0, in_ready=1 after release, next impulse outputs 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR datapath definitions: FSM encoding, width helper and the
// round-half-up / saturate step used by every FIR output stage.
package fir_pkg;

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, ROUND, HOLD} state_t;

  localparam int RS_W = 64;

  typedef struct packed {
    logic signed [RS_W-1:0] val;
    logic                   sat;
  } rs_t;

  // Minimum 1 so a 1-entry index still gets a real port.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic rs_t round_sat(input logic signed [RS_W-1:0] a,
                                    input int shift, input int out_w);
    logic signed [RS_W-1:0] r, hi, lo;
    rs_t o;
    if (shift > 0) r = (a + (64'sd1 <<< (shift - 1))) >>> shift;
    else           r = a;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    o.val = r;
    o.sat = 1'b0;
    if (r > hi) begin
      o.val = hi;
      o.sat = 1'b1;
    end else if (r < lo) begin
      o.val = lo;
      o.sat = 1'b1;
    end
    return o;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer; read port returns the sample 'offset' writes back
// from the most recent one.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = 8,
  parameter int WIDTH    = 16,
  parameter int AW       = clog2(NUM_TAPS)
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic signed [WIDTH-1:0] wdata,
  input  logic                    advance,
  input  logic [AW-1:0]           offset,
  output logic signed [WIDTH-1:0] rdata
);

  localparam logic [AW-1:0] LAST = AW'(NUM_TAPS - 1);

  logic signed [WIDTH-1:0] mem [NUM_TAPS];
  logic [AW-1:0]           wr_ptr, rd_idx;

  // Modulo arithmetic in AW bits stays correct even when NUM_TAPS == 2**AW.
  always_comb begin
    if (wr_ptr >= offset) rd_idx = wr_ptr - offset;
    else                  rd_idx = wr_ptr + AW'(NUM_TAPS) - offset;
  end

  assign rdata = mem[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < NUM_TAPS; i++) mem[i] <= '0;
    end else begin
      if (we) mem[wr_ptr] <= wdata;
      if (advance) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed N-tap FIR: one MAC per cycle over the delay line, then
// round/saturate into a held valid/ready output.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int INPUT_WIDTH  = 16,
  parameter int COEFF_WIDTH  = 16,
  parameter int NUM_TAPS     = 8,
  parameter int ACCUM_WIDTH  = INPUT_WIDTH + COEFF_WIDTH + clog2(NUM_TAPS),
  parameter int OUTPUT_WIDTH = 16,
  parameter int OUT_SHIFT    = 15
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [INPUT_WIDTH-1:0]  in_sample,
  input  logic                           coef_we,
  input  logic [clog2(NUM_TAPS)-1:0]     coef_addr,
  input  logic signed [COEFF_WIDTH-1:0]  coef_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUTPUT_WIDTH-1:0] out_data,
  output logic                           out_sat,
  output logic                           busy
);

  localparam int AW = clog2(NUM_TAPS);
  localparam int PW = INPUT_WIDTH + COEFF_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(NUM_TAPS - 1);

  state_t                        state;
  logic [AW-1:0]                 k;
  logic signed [COEFF_WIDTH-1:0] coef [NUM_TAPS];
  logic signed [PW-1:0]          prod_r;
  logic signed [ACCUM_WIDTH-1:0] acc;
  logic signed [INPUT_WIDTH-1:0] tap;
  logic                          pend_vld;
  logic [AW-1:0]                 pend_addr;
  logic signed [COEFF_WIDTH-1:0] pend_data;
  logic                          accept, coef_ok;
  rs_t                           rs;
  logic                          unused_rs_hi;

  assign accept  = (state == IDLE) && in_valid;
  assign coef_ok = coef_we && (int'(coef_addr) < NUM_TAPS);

  always_comb rs = round_sat(RS_W'(acc), OUT_SHIFT, OUTPUT_WIDTH);
  assign unused_rs_hi = ^rs.val[RS_W-1:OUTPUT_WIDTH];

  fir_delay_line #(.NUM_TAPS(NUM_TAPS), .WIDTH(INPUT_WIDTH), .AW(AW)) u_dline (
    .clk     (clk),
    .reset   (reset),
    .we      (accept),
    .wdata   (in_sample),
    .advance (state == DRAIN),
    .offset  (k),
    .rdata   (tap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      k         <= '0;
      acc       <= '0;
      prod_r    <= '0;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      for (int i = 0; i < NUM_TAPS; i++) coef[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A write landing with an accept is parked so the sample just
          // taken still uses the old coefficient set.
          if (coef_ok) begin
            if (accept) begin
              pend_vld  <= 1'b1;
              pend_addr <= coef_addr;
              pend_data <= coef_data;
            end else begin
              coef[coef_addr] <= coef_data;
            end
          end
          if (accept) begin
            state    <= MAC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            k        <= '0;
            acc      <= '0;
          end
        end
        MAC: begin
          prod_r <= tap * coef[k];
          if (k != '0) acc <= acc + ACCUM_WIDTH'(prod_r);
          if (k == LAST) state <= DRAIN;
          else           k     <= k + 1'b1;
        end
        DRAIN: begin
          acc   <= acc + ACCUM_WIDTH'(prod_r);
          state <= ROUND;
        end
        ROUND: begin
          out_data  <= rs.val[OUTPUT_WIDTH-1:0];
          out_sat   <= rs.sat;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
            if (pend_vld) begin
              coef[pend_addr] <= pend_data;
              pend_vld        <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Scoreboard bench for fir_mac_engine: a behavioural FIR model queues the
// expected output at every accept; the monitor pops and compares on handshake.
module tb_fir_mac_engine;

  localparam int N = 8;

  logic               clk = 1'b0, reset = 1'b1;
  logic               in_valid = 1'b0, in_ready;
  logic signed [15:0] in_sample = '0;
  logic               coef_we = 1'b0;
  logic [2:0]         coef_addr = '0;
  logic signed [15:0] coef_data = '0;
  logic               out_valid, out_ready = 1'b1;
  logic signed [15:0] out_data;
  logic               out_sat, busy;

  fir_mac_engine dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  int     n_checks = 0, n_errors = 0;
  int     hc [N];
  int     xh [N];
  int     xp = 0;
  int     exp_d [$];
  bit     exp_s [$];
  int     obs_d [$];
  bit     obs_s [$];
  longint cyc = 0, acc_edge = 0, hs_edge = 0;
  bit     ov_prev = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_accept(input int x);
    longint acc, r;
    bit     s;
    xh[xp] = x;
    acc = 0;
    for (int i = 0; i < N; i++) acc += longint'(hc[i]) * xh[(xp - i + N) % N];
    xp = (xp + 1) % N;
    r = (acc + 16384) >>> 15;
    s = 1'b0;
    if (r > 32767)       begin r = 32767;  s = 1'b1; end
    else if (r < -32768) begin r = -32768; s = 1'b1; end
    exp_d.push_back(int'(r));
    exp_s.push_back(s);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin hc[i] = 0; xh[i] = 0; end
    xp = 0;
    exp_d.delete();
    exp_s.delete();
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) ov_prev = 1'b0;
    else begin
      if (in_valid && in_ready) begin
        model_accept(int'(in_sample));
        acc_edge = cyc + 1;
      end
      if (out_valid && !ov_prev) check("latency", cyc - acc_edge, 10);
      if (out_valid && out_ready) begin
        hs_edge = cyc + 1;
        obs_d.push_back(int'(out_data));
        obs_s.push_back(out_sat);
        if (exp_d.size() == 0) check("unexpected_out", 1, 0);
        else begin
          check("out_data", out_data, exp_d.pop_front());
          check("out_sat", out_sat, exp_s.pop_front());
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input int x);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_sample = 16'(x);
    wait_accept();
    in_valid = 1'b0;
  endtask

  task automatic wr_coef(input int a, input int d);
    @(posedge clk); #1;
    coef_we = 1'b1; coef_addr = 3'(a); coef_data = 16'(d);
    @(posedge clk); #1;
    coef_we = 1'b0;
    hc[a] = d;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!busy && !out_valid && exp_d.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int imp [9];
    int rnd [4];
    int rx  [4];
    logic signed [15:0] d0;
    logic s0;
    bit seen;

    model_reset();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1 reset = 1'b0;

    // impulse response
    for (int i = 0; i < N; i++) wr_coef(i, i * 1024);
    obs_d.delete(); obs_s.delete();
    send(16384);
    for (int i = 0; i < N; i++) send(0);
    wait_idle();
    for (int i = 0; i < N; i++) imp[i] = i * 512;
    imp[8] = 0;
    check("imp_count", obs_d.size(), 9);
    for (int i = 0; i < 9 && i < obs_d.size(); i++) begin
      check("imp_data", obs_d[i], imp[i]);
      check("imp_sat", obs_s[i], 0);
    end

    // saturation both directions
    for (int i = 0; i < N; i++) wr_coef(i, 32767);
    obs_d.delete(); obs_s.delete();
    for (int i = 0; i < N; i++) send(32767);
    for (int i = 0; i < N; i++) send(-32768);
    wait_idle();
    check("sat_count", obs_d.size(), 16);
    if (obs_d.size() == 16) begin
      check("sat_pos_data", obs_d[7], 32767);
      check("sat_pos_flag", obs_s[7], 1);
      check("sat_neg_data", obs_d[15], -32768);
      check("sat_neg_flag", obs_s[15], 1);
    end

    // round-half-up around the 2^14 boundary
    wr_coef(0, 1);
    for (int i = 1; i < N; i++) wr_coef(i, 0);
    rx[0] = 16384; rx[1] = 16383; rx[2] = -16384; rx[3] = -16385;
    rnd[0] = 1;    rnd[1] = 0;    rnd[2] = 0;      rnd[3] = -1;
    obs_d.delete(); obs_s.delete();
    for (int i = 0; i < 4; i++) send(rx[i]);
    wait_idle();
    check("rnd_count", obs_d.size(), 4);
    for (int i = 0; i < 4 && i < obs_d.size(); i++) check("rnd_data", obs_d[i], rnd[i]);

    // backpressure with the next sample already waiting
    wr_coef(0, 30000);
    out_ready = 1'b0;
    send(1000);
    in_valid = 1'b1; in_sample = 16'sd2000;
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    check("bp_valid_seen", seen, 1);
    d0 = out_data; s0 = out_sat;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_data", out_data, d0);
      check("bp_out_sat", out_sat, s0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    check("bp_next_accept", acc_edge - hs_edge, 1);
    wait_idle();

    // random samples across many pointer wraps
    for (int i = 0; i < N; i++) wr_coef(i, int'($signed(16'($urandom))));
    for (int i = 0; i < 300; i++) send(int'($signed(16'($urandom))));
    wait_idle();

    // coefficient writes while busy must be ignored
    send(5000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      coef_we = 1'b1; coef_addr = 3'(i); coef_data = 16'($urandom);
    end
    @(posedge clk); #1 coef_we = 1'b0;
    wait_idle();
    send(-7000);
    wait_idle();

    // reset in the middle of MAC
    send(12345);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    obs_d.delete(); obs_s.delete();
    send(16384);
    wait_idle();
    check("post_rst_count", obs_d.size(), 1);
    if (obs_d.size() == 1) check("post_rst_data", obs_d[0], 0);

    check("queue_empty", exp_d.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
